// File: rtl/score_wb_dma.sv
// score_wb_dma: write-back DMA for attention result rows.
//
// Accepts one wide result row per row_valid/row_ready handshake. Each row is
// split into W = ROW_ELEMS*CIM_DATA_WIDTH/BUS_DATA_WIDTH bus words, most
// significant word first, and each word is written to consecutive word
// addresses starting at base_address. After row_count rows the block pulses
// done_wb_dma for one cycle and returns to idle.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   en_wb_dma         start request (level, sampled only in IDLE)
//   base_address      byte address of the first word (sampled at start)
//   row_count         number of rows to write (sampled at start)
//   row_data/valid    incoming result row; row_ready is the accept side
//   row_index         row currently expected or being written
//   mem_addr, mem_data_wr, mem_wr_en, mem_ack   memory write bus
//   done_wb_dma       one-cycle completion pulse
//   stall_cycles      (optional) cycles with mem_wr_en=1 and mem_ack=0
//
// Optional feature: define SCORE_WB_STALL_CNT_EN to add the stall_cycles
// counter output. Without it the port and counter do not exist.
module score_wb_dma #(
  parameter int CIM_DATA_WIDTH = 8,
  parameter int BUS_DATA_WIDTH = 32,
  parameter int BUS_ADDR_WIDTH = 32,
  parameter int ROW_ELEMS      = 128,
  parameter int SEQ_LENGTH_BIT = 11
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en_wb_dma,
  input  logic [BUS_ADDR_WIDTH-1:0]           base_address,
  input  logic [SEQ_LENGTH_BIT:0]             row_count,
  input  logic [CIM_DATA_WIDTH*ROW_ELEMS-1:0] row_data,
  input  logic                                row_valid,
  output logic                                row_ready,
  output logic [SEQ_LENGTH_BIT-1:0]           row_index,
  output logic [BUS_DATA_WIDTH-1:0]           mem_data_wr,
  output logic [BUS_ADDR_WIDTH-1:0]           mem_addr,
  output logic                                mem_wr_en,
  input  logic                                mem_ack,
`ifdef SCORE_WB_STALL_CNT_EN
  output logic [31:0]                         stall_cycles,
`endif
  output logic                                done_wb_dma
);

  localparam int ROW_BITS = CIM_DATA_WIDTH * ROW_ELEMS;
  localparam int WORDS    = ROW_BITS / BUS_DATA_WIDTH;
  localparam int WCW      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int RCW      = SEQ_LENGTH_BIT + 1;

  localparam logic [BUS_ADDR_WIDTH-1:0] ADDR_STEP = BUS_ADDR_WIDTH'(BUS_DATA_WIDTH / 8);
  localparam logic [WCW-1:0]            LAST_WORD = WCW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ROW,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                      state_q, state_d;
  logic [ROW_BITS-1:0]         row_buf_q, row_buf_d;
  logic [WCW-1:0]              word_cnt_q, word_cnt_d;
  logic [RCW-1:0]              rows_left_q, rows_left_d;
  logic                        row_ready_q, row_ready_d;
  logic [SEQ_LENGTH_BIT-1:0]   row_index_q, row_index_d;
  logic [BUS_DATA_WIDTH-1:0]   mem_data_wr_q, mem_data_wr_d;
  logic [BUS_ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                        mem_wr_en_q, mem_wr_en_d;
  logic                        done_q, done_d;
  logic [ROW_BITS-1:0]         row_shifted;
`ifdef SCORE_WB_STALL_CNT_EN
  logic [31:0]                 stall_q, stall_d;
`endif

  // The row buffer shifts left one word per accepted write, so the word on
  // the bus is always taken from its top slice.
  assign row_shifted = row_buf_q << BUS_DATA_WIDTH;

  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    row_buf_d     = row_buf_q;
    word_cnt_d    = word_cnt_q;
    rows_left_d   = rows_left_q;
    row_ready_d   = row_ready_q;
    row_index_d   = row_index_q;
    mem_data_wr_d = mem_data_wr_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_en_d   = mem_wr_en_q;
    done_d        = 1'b0;
`ifdef SCORE_WB_STALL_CNT_EN
    stall_d       = stall_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (en_wb_dma) begin
          // mem_addr_q doubles as the running address register.
          mem_addr_d  = base_address;
          rows_left_d = row_count;
          row_index_d = '0;
          word_cnt_d  = '0;
`ifdef SCORE_WB_STALL_CNT_EN
          stall_d     = '0;
`endif
          if (row_count == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = S_WAIT_ROW;
            row_ready_d = 1'b1;
          end
        end
      end

      S_WAIT_ROW: begin
        if (row_valid && row_ready_q) begin
          row_buf_d     = row_data;
          mem_data_wr_d = row_data[ROW_BITS-1 -: BUS_DATA_WIDTH];
          row_ready_d   = 1'b0;
          mem_wr_en_d   = 1'b1;
          state_d       = S_WRITE;
        end
      end

      S_WRITE: begin
`ifdef SCORE_WB_STALL_CNT_EN
        if (!mem_ack && (stall_q != '1)) begin
          stall_d = stall_q + 32'd1;
        end
`endif
        if (mem_ack) begin
          // The address keeps running across rows, giving
          // base + step*(row_index*W + k) without a multiplier.
          mem_addr_d    = mem_addr_q + ADDR_STEP;
          row_buf_d     = row_shifted;
          mem_data_wr_d = row_shifted[ROW_BITS-1 -: BUS_DATA_WIDTH];
          word_cnt_d    = word_cnt_q + WCW'(1);
          if (word_cnt_q == LAST_WORD) begin
            word_cnt_d  = '0;
            mem_wr_en_d = 1'b0;
            if (rows_left_q == RCW'(1)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              rows_left_d = rows_left_q - RCW'(1);
              row_index_d = row_index_q + SEQ_LENGTH_BIT'(1);
              row_ready_d = 1'b1;
              state_d     = S_WAIT_ROW;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values computed before the edge regardless of block order.
  // NOTE: the row buffer is a plain register bank, not RAM, so it is cleared
  // on reset together with the counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      row_buf_q     <= '0;
      word_cnt_q    <= '0;
      rows_left_q   <= '0;
      row_ready_q   <= 1'b0;
      row_index_q   <= '0;
      mem_data_wr_q <= '0;
      mem_addr_q    <= '0;
      mem_wr_en_q   <= 1'b0;
      done_q        <= 1'b0;
`ifdef SCORE_WB_STALL_CNT_EN
      stall_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      row_buf_q     <= row_buf_d;
      word_cnt_q    <= word_cnt_d;
      rows_left_q   <= rows_left_d;
      row_ready_q   <= row_ready_d;
      row_index_q   <= row_index_d;
      mem_data_wr_q <= mem_data_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_en_q   <= mem_wr_en_d;
      done_q        <= done_d;
`ifdef SCORE_WB_STALL_CNT_EN
      stall_q       <= stall_d;
`endif
    end
  end

  assign row_ready   = row_ready_q;
  assign row_index   = row_index_q;
  assign mem_data_wr = mem_data_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign done_wb_dma = done_q;
`ifdef SCORE_WB_STALL_CNT_EN
  assign stall_cycles = stall_q;
`endif

endmodule
